// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared rv32i core constants and writeback types
package regfile_wb_scheduler_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LQ} wb_src_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: issue, writeback and reg_file write-port signals
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;
    logic issue_valid;
    logic issue_is_load;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] issue_rs1;
    logic [REG_ADDR_W-1:0] issue_rs2;
    logic issue_stall;
    logic alu_wb_valid;
    logic [REG_ADDR_W-1:0] alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic ld_wb_valid;
    logic ld_wb_ready;
    logic [REG_ADDR_W-1:0] ld_wb_rd;
    logic [XLEN-1:0] ld_wb_data;
    logic hold_alu;
    logic rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [NUM_REGS-1:0] busy_vec;
    modport master (
        output issue_valid, issue_is_load, issue_rd, issue_rs1, issue_rs2,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output ld_wb_valid, ld_wb_rd, ld_wb_data,
        input issue_stall, ld_wb_ready, hold_alu, rf_we, rf_rd, rf_wdata, busy_vec
    );
    modport slave (
        input issue_valid, issue_is_load, issue_rd, issue_rs1, issue_rs2,
        input alu_wb_valid, alu_wb_rd, alu_wb_data,
        input ld_wb_valid, ld_wb_rd, ld_wb_data,
        output issue_stall, ld_wb_ready, hold_alu, rf_we, rf_rd, rf_wdata, busy_vec
    );
endinterface

// File: rtl/regfile_wb_scheduler_wb_load_fifo.sv
// wb_load_fifo: load-return queue of {rd, data}; ready depends only on registered pointers
module wb_load_fifo
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_valid,
    output logic      push_ready,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic push, do_pop;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign push_ready = !((wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
    assign head = mem_q[rd_ptr_q[AW-1:0]];
    assign push = push_valid && push_ready;
    assign do_pop = pop && !empty;
    // next storage and pointer state
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end
    // pointers reset to empty; payload storage needs no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the reg_file write port between ALU and load returns with a load scoreboard
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic rst,
    regfile_wb_scheduler_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    wb_entry_t lq_head;
    logic lq_empty, lq_pop, lq_ready, accept, starving;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic rf_we_q, rf_we_d, hold_q, hold_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d, win_rd;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    wb_src_e src_q, src_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk(clk),
        .rst(rst),
        .push_valid(bus.ld_wb_valid),
        .push_ready(lq_ready),
        .push_data('{rd: bus.ld_wb_rd, data: bus.ld_wb_data}),
        .pop(lq_pop),
        .head(lq_head),
        .empty(lq_empty)
    );
    assign bus.issue_stall = bus.issue_valid &&
        (busy_q[bus.issue_rs1] || busy_q[bus.issue_rs2] || busy_q[bus.issue_rd]);
    assign accept = bus.issue_valid && !bus.issue_stall;
    assign bus.ld_wb_ready = lq_ready;
    assign bus.hold_alu = hold_q;
    assign bus.rf_we = rf_we_q;
    assign bus.rf_rd = rf_rd_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy_vec = busy_q;
    // arbitration (ALU first), scoreboard update and starvation counter
    always_comb begin
        src_d = bus.alu_wb_valid ? SRC_ALU : (lq_empty ? SRC_NONE : SRC_LQ);
        lq_pop = src_d == SRC_LQ;
        win_rd = bus.alu_wb_valid ? bus.alu_wb_rd : lq_head.rd;
        rf_we_d = (src_d != SRC_NONE) && (win_rd != '0);
        rf_rd_d = (src_d == SRC_NONE) ? rf_rd_q : win_rd;
        rf_wdata_d = (src_d == SRC_NONE) ? rf_wdata_q :
                     (bus.alu_wb_valid ? bus.alu_wb_data : lq_head.data);
        busy_d = busy_q;
        if (rf_we_q && src_q == SRC_LQ) busy_d[rf_rd_q] = 1'b0;
        if (accept && bus.issue_is_load && bus.issue_rd != '0) busy_d[bus.issue_rd] = 1'b1;
        starving = bus.alu_wb_valid && !lq_empty;
        cnt_nxt = cnt_q + CW'(1);
        hold_d = starving && cnt_nxt == CW'(STARVE_MAX);
        cnt_d = (starving && !hold_d) ? cnt_nxt : '0;
    end
    // registered write port, scoreboard and fairness state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wdata_q <= '0;
            src_q <= SRC_NONE;
            hold_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            busy_q <= busy_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            src_q <= src_d;
            hold_q <= hold_d;
            cnt_q <= cnt_d;
        end
    end
    alu_to_busy_rd: assert property (@(posedge clk) disable iff (rst)
        !(bus.alu_wb_valid && busy_q[bus.alu_wb_rd]));
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed checks of arbitration, scoreboard, fairness and reset
module tb_regfile_wb_scheduler;
    logic clk, rst;
    int checks = 0;
    int failures = 0;
    regfile_wb_scheduler_if bus();
    regfile_wb_scheduler #(.LQ_DEPTH(2), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_is_load = 0; bus.issue_rd = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
        bus.alu_wb_valid = 0; bus.alu_wb_rd = 0; bus.alu_wb_data = 0;
        bus.ld_wb_valid = 0; bus.ld_wb_rd = 0; bus.ld_wb_data = 0;
    endtask

    task automatic issue(input logic ld, input logic [4:0] rd, rs1, rs2);
        bus.issue_valid = 1; bus.issue_is_load = ld; bus.issue_rd = rd; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_wb_valid = v; bus.alu_wb_rd = rd; bus.alu_wb_data = d;
    endtask

    task automatic ldr(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ld_wb_valid = v; bus.ld_wb_rd = rd; bus.ld_wb_data = d;
    endtask

    always @(negedge clk) if (!rst && bus.hold_alu && bus.alu_wb_valid) begin
        checks++;
        failures++;
        $error("FAIL hold_protocol observed=alu_wb_valid during hold_alu expected=idle");
    end

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_busy", bus.busy_vec, 0);
        chk("rst_ready", 32'(bus.ld_wb_ready), 1);
        chk("rst_hold", 32'(bus.hold_alu), 0);
        chk("rst_rf_rd", 32'(bus.rf_rd), 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);

        issue(1, 5, 1, 2); #1;
        chk("ld5_nostall", 32'(bus.issue_stall), 0);
        tick();
        chk("ld5_busy", bus.busy_vec, 32'h20);
        issue(0, 6, 5, 0); #1;
        chk("raw5_stall", 32'(bus.issue_stall), 1);
        tick();
        ldr(1, 5, 32'hDEADBEEF); #1;
        chk("raw5_stall_hold", 32'(bus.issue_stall), 1);
        chk("ld5_ready", 32'(bus.ld_wb_ready), 1);
        tick();
        ldr(0, 0, 0); #1;
        chk("ld5_queued_we", 32'(bus.rf_we), 0);
        chk("ld5_queued_stall", 32'(bus.issue_stall), 1);
        tick();
        chk("ld5_we", 32'(bus.rf_we), 1);
        chk("ld5_rd", 32'(bus.rf_rd), 5);
        chk("ld5_data", bus.rf_wdata, 32'hDEADBEEF);
        chk("ld5_stall_commit", 32'(bus.issue_stall), 1);
        tick();
        chk("ld5_busy_clr", bus.busy_vec, 0);
        chk("ld5_stall_drop", 32'(bus.issue_stall), 0);
        bus.issue_valid = 0;
        tick();

        alu(1, 3, 32'h33); ldr(1, 7, 32'h77);
        tick();
        alu(0, 0, 0); ldr(0, 0, 0);
        chk("both_we", 32'(bus.rf_we), 1);
        chk("both_alu_rd", 32'(bus.rf_rd), 3);
        chk("both_alu_data", bus.rf_wdata, 32'h33);
        chk("both_one_entry_ready", 32'(bus.ld_wb_ready), 1);
        tick();
        chk("both_ld_we", 32'(bus.rf_we), 1);
        chk("both_ld_rd", 32'(bus.rf_rd), 7);
        chk("both_ld_data", bus.rf_wdata, 32'h77);
        tick();
        chk("both_idle_we", 32'(bus.rf_we), 0);

        alu(1, 10, 32'hA0); ldr(1, 11, 32'h111);
        tick();
        alu(1, 10, 32'hA1); ldr(1, 12, 32'h112); #1;
        chk("fill_ready_one", 32'(bus.ld_wb_ready), 1);
        tick();
        chk("fill_full", 32'(bus.ld_wb_ready), 0);
        alu(1, 10, 32'hA2); ldr(1, 13, 32'h113);
        tick();
        alu(1, 10, 32'hA3);
        chk("starve_hold_a3", 32'(bus.hold_alu), 0);
        tick();
        alu(1, 10, 32'hA4);
        chk("starve_hold_a4", 32'(bus.hold_alu), 0);
        tick();
        alu(0, 0, 0); ldr(0, 0, 0);
        chk("starve_hold", 32'(bus.hold_alu), 1);
        chk("starve_full", 32'(bus.ld_wb_ready), 0);
        chk("starve_alu_rd", 32'(bus.rf_rd), 10);
        chk("starve_alu_data", bus.rf_wdata, 32'hA4);
        tick();
        chk("drain_hold_off", 32'(bus.hold_alu), 0);
        chk("drain_we", 32'(bus.rf_we), 1);
        chk("drain_rd11", 32'(bus.rf_rd), 11);
        chk("drain_data11", bus.rf_wdata, 32'h111);
        chk("drain_ready", 32'(bus.ld_wb_ready), 1);
        tick();
        chk("drain_rd12", 32'(bus.rf_rd), 12);
        chk("drain_data12", bus.rf_wdata, 32'h112);
        tick();
        chk("drain_no13", 32'(bus.rf_we), 0);

        issue(1, 0, 0, 0); #1;
        chk("x0_nostall", 32'(bus.issue_stall), 0);
        tick();
        bus.issue_valid = 0;
        chk("x0_busy", bus.busy_vec, 0);
        ldr(1, 0, 32'hFFFFFFFF);
        tick();
        ldr(1, 8, 32'h88); #1;
        chk("x0_queued_we", 32'(bus.rf_we), 0);
        tick();
        ldr(0, 0, 0);
        chk("x0_pop_we", 32'(bus.rf_we), 0);
        chk("x0_pop_rd", 32'(bus.rf_rd), 0);
        tick();
        chk("x8_we", 32'(bus.rf_we), 1);
        chk("x8_rd", 32'(bus.rf_rd), 8);
        chk("x8_data", bus.rf_wdata, 32'h88);
        tick();

        issue(1, 5, 0, 0); #1;
        chk("r_ld5_nostall", 32'(bus.issue_stall), 0);
        tick();
        issue(1, 9, 0, 0); #1;
        chk("r_ld9_nostall", 32'(bus.issue_stall), 0);
        tick();
        bus.issue_valid = 0;
        alu(1, 1, 32'h1); ldr(1, 5, 32'h555);
        tick();
        alu(1, 2, 32'h2); ldr(1, 9, 32'h999);
        tick();
        chk("r_busy", bus.busy_vec, 32'h220);
        chk("r_full", 32'(bus.ld_wb_ready), 0);
        rst = 1;
        alu(0, 0, 0); ldr(0, 0, 0);
        tick();
        rst = 0;
        chk("r_busy_clr", bus.busy_vec, 0);
        chk("r_ready", 32'(bus.ld_wb_ready), 1);
        chk("r_we", 32'(bus.rf_we), 0);
        chk("r_hold", 32'(bus.hold_alu), 0);
        tick();
        chk("r_no_write1", 32'(bus.rf_we), 0);
        tick();
        chk("r_no_write2", 32'(bus.rf_we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
